// File: rtl/dma_mem_responder_pkg.sv
// Shared types and sizing for the DMA memory responder.
// Line index is taken from the byte address above the cache-line offset.
package dma_resp_pkg;

    localparam int ADDR_WIDTH       = 64;
    localparam int SIZE_WIDTH       = 43;
    localparam int DATA_WIDTH       = 512;
    localparam int MEM_LINES_LOG2   = 10;
    localparam int FIFO_DEPTH       = 8;
    localparam int LINE_OFFSET_BITS = 6;

    typedef logic [DATA_WIDTH-1:0]     line_t;
    typedef logic [SIZE_WIDTH-1:0]     count_t;
    typedef logic [MEM_LINES_LOG2-1:0] lidx_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ACTIVE,
        RD_DONE
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ACTIVE,
        WR_DONE
    } wr_state_t;

endpackage

// File: rtl/dma_mem_responder_if.sv
// DMA request/stream/completion bundle plus bench throttles and backdoor.
// The master drives requests and streams; the slave is the responder.
interface dma_mem_responder_if;
    import dma_resp_pkg::*;

    logic                  rd_go;
    logic [ADDR_WIDTH-1:0] rd_addr;
    count_t                rd_size;
    logic                  rd_en;
    line_t                 rd_data;
    logic                  empty;
    logic                  rd_done;

    logic                  wr_go;
    logic [ADDR_WIDTH-1:0] wr_addr;
    count_t                wr_size;
    logic                  wr_en;
    line_t                 wr_data;
    logic                  full;
    logic                  wr_done;

    logic                  rd_stall;
    logic                  wr_stall;

    logic                  bd_we;
    lidx_t                 bd_addr;
    line_t                 bd_wdata;
    line_t                 bd_rdata;

    logic                  err;

    modport master (
        output rd_go, rd_addr, rd_size, rd_en,
        output wr_go, wr_addr, wr_size, wr_en, wr_data,
        output rd_stall, wr_stall,
        output bd_we, bd_addr, bd_wdata,
        input  rd_data, empty, rd_done,
        input  full, wr_done, bd_rdata, err
    );

    modport slave (
        input  rd_go, rd_addr, rd_size, rd_en,
        input  wr_go, wr_addr, wr_size, wr_en, wr_data,
        input  rd_stall, wr_stall,
        input  bd_we, bd_addr, bd_wdata,
        output rd_data, empty, rd_done,
        output full, wr_done, bd_rdata, err
    );

endinterface

// File: rtl/dma_mem_responder_sc_fifo.sv
// Single-clock FIFO with registered full/empty and an occupancy count.
// The head reads as zero while empty so the output is defined after reset.
module sc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_count_nxt;

    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + CNT_ONE;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)
                r_rptr <= r_rptr + PTR_ONE;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_FULL);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_empty ? '0 : r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/dma_mem_responder.sv
// DMA peripheral responder: streams cache lines between a local line
// memory and the AFU-side read/write FIFOs, with a bench backdoor.
module dma_mem_responder
    import dma_resp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    dma_mem_responder_if.slave  bus
);

    localparam int     FCW       = $clog2(FIFO_DEPTH) + 1;
    localparam int     MEM_LINES = 1 << MEM_LINES_LOG2;
    localparam count_t CNT_ONE   = count_t'(1);
    localparam lidx_t  IDX_ONE   = lidx_t'(1);

    line_t     r_mem [MEM_LINES];
    line_t     r_mem_q;
    logic      r_mem_vld;
    line_t     r_bd_rdata;

    rd_state_t r_rd_state;
    count_t    r_rd_size;
    count_t    r_rd_fetched;
    count_t    r_rd_popped;
    lidx_t     r_rd_ptr;
    logic      r_rd_done;

    wr_state_t r_wr_state;
    count_t    r_wr_size;
    count_t    r_wr_accepted;
    count_t    r_wr_drained;
    lidx_t     r_wr_ptr;
    logic      r_wr_done;

    logic      r_err;

    line_t          w_rf_rdata;
    logic           w_rf_full;
    logic           w_rf_empty;
    logic [FCW-1:0] w_rf_count;
    line_t          w_wf_rdata;
    logic           w_wf_full;
    logic           w_wf_empty;
    logic [FCW-1:0] w_wf_count;

    logic  w_rd_room;
    logic  w_rd_issue;
    logic  w_rd_pop;
    logic  w_wr_push;
    logic  w_wr_drain;
    logic  w_rd_active;
    logic  w_wr_active;
    logic  w_err_evt;
    lidx_t w_rd_start;
    lidx_t w_wr_start;
    logic  w_unused;

    assign w_rd_start  = bus.rd_addr[LINE_OFFSET_BITS +: MEM_LINES_LOG2];
    assign w_wr_start  = bus.wr_addr[LINE_OFFSET_BITS +: MEM_LINES_LOG2];
    assign w_rd_active = (r_rd_state == RD_ACTIVE);
    assign w_wr_active = (r_wr_state == WR_ACTIVE);

    // An in-flight RAM read already owns one FIFO slot.
    assign w_rd_room = r_mem_vld ? (w_rf_count < FCW'(FIFO_DEPTH - 1))
                                 : (w_rf_count < FCW'(FIFO_DEPTH));

    // Reads wait for the write FIFO to drain so they see prior writes.
    assign w_rd_issue = w_rd_active && (r_rd_fetched < r_rd_size)
                        && w_rd_room && !bus.rd_stall && w_wf_empty;
    assign w_rd_pop   = bus.rd_en && !w_rf_empty;

    assign w_wr_push  = bus.wr_en && w_wr_active && !w_wf_full
                        && (r_wr_accepted < r_wr_size);
    assign w_wr_drain = w_wr_active && !w_wf_empty
                        && !bus.wr_stall && !bus.bd_we;

    assign w_err_evt = (bus.rd_en && w_rf_empty)
                     || (bus.wr_en && !w_wr_push)
                     || (bus.rd_go && w_rd_active)
                     || (bus.wr_go && w_wr_active);

    sc_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_mem_vld),
        .i_wdata (r_mem_q),
        .i_pop   (w_rd_pop),
        .o_rdata (w_rf_rdata),
        .o_full  (w_rf_full),
        .o_empty (w_rf_empty),
        .o_count (w_rf_count)
    );

    sc_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_wr_push),
        .i_wdata (bus.wr_data),
        .i_pop   (w_wr_drain),
        .o_rdata (w_wf_rdata),
        .o_full  (w_wf_full),
        .o_empty (w_wf_empty),
        .o_count (w_wf_count)
    );

    // Memory contents survive reset; backdoor writes preempt the drain.
    always_ff @(posedge clk) begin
        if (bus.bd_we)
            r_mem[bus.bd_addr] <= bus.bd_wdata;
        else if (w_wr_drain)
            r_mem[r_wr_ptr] <= w_wf_rdata;
        if (w_rd_issue)
            r_mem_q <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_bd_rdata <= '0;
        else
            r_bd_rdata <= r_mem[bus.bd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state   <= RD_IDLE;
            r_rd_size    <= '0;
            r_rd_fetched <= '0;
            r_rd_popped  <= '0;
            r_rd_ptr     <= '0;
            r_rd_done    <= 1'b0;
            r_mem_vld    <= 1'b0;
        end else begin
            r_mem_vld <= w_rd_issue;
            unique case (r_rd_state)
                RD_ACTIVE: begin
                    if (w_rd_issue) begin
                        r_rd_fetched <= r_rd_fetched + CNT_ONE;
                        r_rd_ptr     <= r_rd_ptr + IDX_ONE;
                    end
                    if (w_rd_pop) begin
                        r_rd_popped <= r_rd_popped + CNT_ONE;
                        if (r_rd_popped == r_rd_size - CNT_ONE) begin
                            r_rd_state <= RD_DONE;
                            r_rd_done  <= 1'b1;
                        end
                    end
                end
                RD_IDLE, RD_DONE: begin
                    if (bus.rd_go) begin
                        r_rd_size    <= bus.rd_size;
                        r_rd_fetched <= '0;
                        r_rd_popped  <= '0;
                        r_rd_ptr     <= w_rd_start;
                        r_rd_done    <= (bus.rd_size == '0);
                        r_rd_state   <= (bus.rd_size == '0) ? RD_DONE
                                                            : RD_ACTIVE;
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state    <= WR_IDLE;
            r_wr_size     <= '0;
            r_wr_accepted <= '0;
            r_wr_drained  <= '0;
            r_wr_ptr      <= '0;
            r_wr_done     <= 1'b0;
        end else begin
            unique case (r_wr_state)
                WR_ACTIVE: begin
                    if (w_wr_push)
                        r_wr_accepted <= r_wr_accepted + CNT_ONE;
                    if (w_wr_drain) begin
                        r_wr_drained <= r_wr_drained + CNT_ONE;
                        r_wr_ptr     <= r_wr_ptr + IDX_ONE;
                        if (r_wr_drained == r_wr_size - CNT_ONE) begin
                            r_wr_state <= WR_DONE;
                            r_wr_done  <= 1'b1;
                        end
                    end
                end
                WR_IDLE, WR_DONE: begin
                    if (bus.wr_go) begin
                        r_wr_size     <= bus.wr_size;
                        r_wr_accepted <= '0;
                        r_wr_drained  <= '0;
                        r_wr_ptr      <= w_wr_start;
                        r_wr_done     <= (bus.wr_size == '0);
                        r_wr_state    <= (bus.wr_size == '0) ? WR_DONE
                                                             : WR_ACTIVE;
                    end
                end
                default: r_wr_state <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_err_evt)
            r_err <= 1'b1;
    end

    assign bus.rd_data  = w_rf_rdata;
    assign bus.empty    = w_rf_empty;
    assign bus.rd_done  = r_rd_done;
    assign bus.full     = w_wf_full;
    assign bus.wr_done  = r_wr_done;
    assign bus.bd_rdata = r_bd_rdata;
    assign bus.err      = r_err;

    assign w_unused = ^{w_rf_full, w_wf_count,
                        bus.rd_addr[LINE_OFFSET_BITS-1:0],
                        bus.rd_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS+MEM_LINES_LOG2],
                        bus.wr_addr[LINE_OFFSET_BITS-1:0],
                        bus.wr_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS+MEM_LINES_LOG2]};

endmodule

// File: doc/dma_mem_responder.md
# dma_mem_responder

Self-contained responder for the peripheral side of `dma_if`: it services read and write cache-line requests from an AFU-side master such as `proc_hier` out of a local dual-port cache-line memory. It lets processor hierarchy tests run in plain RTL simulation, without ASE or a host. The block implements the DMA end of the protocol that `afu` consumes: go/addr/size request, empty/rd_en read stream, full/wr_en write stream, and rd_done/wr_done completion. A backdoor port lets the bench preload and inspect memory.

## Interface
- `ADDR_WIDTH`, 64: virtual byte address width.
- `SIZE_WIDTH`, 43: transfer size width in cache lines (`$size(t_ccip_clAddr)+1`).
- `DATA_WIDTH`, 512: cache-line width.
- `MEM_LINES_LOG2`, 10: log2 of memory depth in lines.
- `FIFO_DEPTH`, 8: depth of the read FIFO and of the write FIFO; a power of 2, at least 2.
- `clk`  in  1: clock. One clock only; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rd_go`  in  1: start-read pulse; samples `rd_addr` and `rd_size`.
- `rd_addr`  in  ADDR_WIDTH: byte address of the first line to read.
- `rd_size`  in  SIZE_WIDTH: number of lines to read.
- `rd_en`  in  1: pops the read FIFO head.
- `rd_data`  out  DATA_WIDTH: read FIFO head; valid when `!empty`.
- `empty`  out  1: read FIFO empty.
- `rd_done`  out  1: read transfer complete.
- `wr_go`, `wr_addr`, `wr_size`  in: write-channel counterparts of `rd_go`, `rd_addr`, `rd_size`.
- `wr_en`  in  1: pushes `wr_data` into the write FIFO.
- `wr_data`  in  DATA_WIDTH: line to be written.
- `full`  out  1: write FIFO full.
- `wr_done`  out  1: write transfer complete.
- `rd_stall`, `wr_stall`  in  1: bench throttles; while high, memory fetch (read) or drain (write) is inhibited.
- `bd_we`  in  1: backdoor write enable.
- `bd_addr`  in  MEM_LINES_LOG2: backdoor line index.
- `bd_wdata`  in  DATA_WIDTH: backdoor write data.
- `bd_rdata`  out  DATA_WIDTH: backdoor read data; 1-cycle latency.
- `err`  out  1: sticky protocol-violation flag.

## Operation
- Line index is `addr[6 +: MEM_LINES_LOG2]`. Byte offset bits `[5:0]` are ignored. Indices wrap modulo 2^MEM_LINES_LOG2.
- Read FSM states: `RD_IDLE`, `RD_ACTIVE`, `RD_DONE`.
  - `rd_go` from any non-active state: latch the start index and size, clear `rd_done`, go to `RD_ACTIVE`.
  - Size 0: go straight to `RD_DONE`.
- In `RD_ACTIVE`, issue one memory read per cycle when all of these hold:
  - fetched count < size;
  - read FIFO occupancy plus in-flight reads < `FIFO_DEPTH`;
  - `!rd_stall`;
  - the write FIFO is empty. This gives read-after-write ordering.
- Returned data enters the read FIFO. `RD_ACTIVE` moves to `RD_DONE` when popped count equals size.
- Write FSM states: `WR_IDLE`, `WR_ACTIVE`, `WR_DONE`, with the same go/size handling as the read FSM.
  - In `WR_ACTIVE`, the write FIFO drains one line per cycle to the memory write port when non-empty and `!wr_stall`.
  - `WR_ACTIVE` moves to `WR_DONE` when drained count equals size.
- The memory write port is shared. A backdoor write wins; the write drain stalls that cycle.
- `bd_rdata` uses a third read path (or a time-shared port). Its result is visible one cycle after `bd_addr` is applied.
- `err` is set, and the event is dropped, on any of:
  - `rd_en` while `empty`;
  - `wr_en` while `full`;
  - `wr_en` outside `WR_ACTIVE`;
  - `wr_en` beyond `wr_size` accepted lines;
  - `rd_go` while `RD_ACTIVE`;
  - `wr_go` while `WR_ACTIVE`.
- `rd_done` and `wr_done` stay high until the next accepted go on their channel.

## Timing
- Reset values: `empty`=1, `full`=0, `rd_done`=0, `wr_done`=0, `err`=0, `rd_data`=0, `bd_rdata`=0.
- Reset clears both FSMs, both FIFOs, and all counters. Memory contents are retained, including on reset mid-transfer.
- Read latency: `rd_go` at cycle 0 → memory read issued at cycle 1 → `empty` falls at cycle 3 (registered RAM output, then FIFO write).
- Read throughput: with `rd_en` held high, 1 line per cycle sustained.
- Write: `wr_en` at cycle n → memory written at cycle n+1 at the earliest. `wr_done` rises the cycle after the last line is drained.
- Simultaneous push and pop on a FIFO leaves occupancy unchanged.
- `full` reflects occupancy = `FIFO_DEPTH` including a same-cycle drain: it is registered with no combinational `wr_en` path.
- `rd_go` and `wr_go` in the same cycle are both accepted.

## Structure
- Package `dma_resp_pkg`: `line_t` (DATA_WIDTH), `count_t` (SIZE_WIDTH), the read/write FSM state enums, and the `LINE_OFFSET_BITS`=6 constant.
- One sub-module, `sc_fifo` (parameterised width/depth, registered `full`/`empty`, count output), instantiated twice.

## Test plan
- Preload lines 0..15 with value = index via backdoor. `rd_go` with addr `0x40`, size 4, `rd_en` held high → data 1,2,3,4 on consecutive cycles. `rd_done` rises after the 4th pop. `err`=0.
- `wr_go` with addr `0x100`, size 3. Write `A`,`B`,`C` back-to-back → `wr_done` rises. Backdoor reads of lines 4,5,6 return `A`,`B`,`C`.
- `wr_stall`=1, `wr_go` size 12. Push until `full`: exactly 8 accepted. A 9th `wr_en` sets `err`. Release the stall → 8 lines written, `wr_done` stays 0.
- Wrap-around: `rd_go` at line 1022, size 4 → lines 1022, 1023, 0, 1 in order.
- Size 0 on both channels → `rd_done` and `wr_done` high 1 cycle after go. No memory access.
- Assert `rst` mid-read with 2 lines popped → `empty`=1 and `rd_done`=0 the next cycle. A new `rd_go` restarts cleanly. Memory is unchanged.
